rr_busarb: RTL and testbench

RR_BUSARB -- requirements
Module: rr_busarb

---
 rtl/rr_busarb.sv | 100 ++++++++++
 tb/tb_rr_busarb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_busarb.sv
// rr_busarb: four-requester round-robin bus arbiter with active-low requests and grants.
// A grant is held until the owner drops its request. It is revoked after MAX_TENURE cycles
// if another requester is waiting and the owner has not locked the bus. Every hand-over
// passes through at least one idle cycle so the bus can turn around.
module rr_busarb #(
    parameter int unsigned MAX_TENURE = 16,
    parameter int unsigned PARK_ID    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] breq_,
    input  logic [3:0] lock_,
    output logic [3:0] bgrt_,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       preempt
);

    // The counter has at least 4 bits, and enough bits to hold MAX_TENURE-1.
    localparam int unsigned TW = (MAX_TENURE > 16) ? $clog2(MAX_TENURE) : 4;
    localparam logic [TW-1:0] TEN_LAST = (MAX_TENURE == 0) ? '0 : TW'(MAX_TENURE - 1);
    localparam logic [1:0] PARK = 2'(PARK_ID);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q;
    logic [TW-1:0]   tenure_q;
    logic [1:0]      scan_idx;
    logic [1:0]      win;
    logic            win_found;
    logic            own_rel;
    logic            own_locked;
    logic            others_req;
    logic            timeout;

    // gnt_id always equals the last owner, so it also serves as the round-robin pointer.
    // Find the first active request, scanning from the id after the last owner and wrapping
    // back to the last owner itself.
    always_comb begin
        win       = gnt_id;
        win_found = 1'b0;
        scan_idx  = gnt_id;
        for (int i = 1; i <= 4; i++) begin
            scan_idx = gnt_id + 2'(i);
            if (!win_found && !breq_[scan_idx]) begin
                win_found = 1'b1;
                win       = scan_idx;
            end
        end
    end

    // The owner releases by raising its request. Only its own lock bit matters.
    assign own_rel    = breq_[gnt_id];
    assign own_locked = ~lock_[gnt_id];
    assign others_req = |(~breq_ & ~(4'b0001 << gnt_id));
    assign timeout    = (MAX_TENURE != 0) && (tenure_q == TEN_LAST) && others_req && !own_locked;

    // Arbiter FSM. All outputs except busy are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            bgrt_    <= 4'b1111;
            gnt_id   <= PARK;
            tenure_q <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_q  <= StGrant;
                        bgrt_    <= ~(4'b0001 << win);
                        gnt_id   <= win;
                        tenure_q <= '0;
                    end
                end
                StGrant: begin
                    // A release takes precedence over a timeout on the same edge.
                    if (own_rel) begin
                        state_q <= StIdle;
                        bgrt_   <= 4'b1111;
                    end else if (timeout) begin
                        state_q <= StIdle;
                        bgrt_   <= 4'b1111;
                        preempt <= 1'b1;
                    end else if (tenure_q != '1) begin
                        tenure_q <= tenure_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    bgrt_   <= 4'b1111;
                end
            endcase
        end
    end

    assign busy = (state_q == StGrant);

endmodule

// File: tb/tb_rr_busarb.sv
// Testbench for rr_busarb: a directed table, hand-written multi-cycle sequences,
// and a random run compared cycle by cycle against a behavioural model.
`timescale 1ns/1ps
module tb_rr_busarb;

    localparam int MAXT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] breq_;
    logic [3:0] lock_;
    logic [3:0] bgrt_;
    logic [1:0] gnt_id;
    logic       busy;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    // Behavioural model: owner id (-1 when idle), last owner, cycles owned so far.
    int m_owner;
    int m_last;
    int m_cycles;
    bit m_pre;

    rr_busarb #(
        .MAX_TENURE(MAXT),
        .PARK_ID   (0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .breq_  (breq_),
        .lock_  (lock_),
        .bgrt_  (bgrt_),
        .gnt_id (gnt_id),
        .busy   (busy),
        .preempt(preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 0;
        m_cycles = 0;
        m_pre    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] rq, input logic [3:0] lk);
        bit others;
        bit done;
        int c;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            done = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (!done && !rq[c]) begin
                    m_owner  = c;
                    m_last   = c;
                    m_cycles = 1;
                    done     = 1'b1;
                end
            end
        end else begin
            others = 1'b0;
            for (int k = 0; k < 4; k++)
                if (k != m_owner && !rq[k]) others = 1'b1;
            if (rq[m_owner]) begin
                m_owner = -1;
            end else if (MAXT != 0 && m_cycles == MAXT && others && lk[m_owner]) begin
                m_owner = -1;
                m_pre   = 1'b1;
            end else if (m_cycles < 1000) begin
                m_cycles++;
            end
        end
    endtask

    function automatic logic [3:0] m_bgrt();
        logic [3:0] one;
        one = 4'b0001;
        return (m_owner < 0) ? 4'b1111 : ~(one << m_owner);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".bgrt"}, 32'(bgrt_), 32'(m_bgrt()));
        chk({tag, ".id"}, 32'(gnt_id), 32'(m_last));
        chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
        chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
    endtask

    // Drive on the falling edge, let one rising edge pass, return 1 ns after it.
    task automatic step(input logic [3:0] rq, input logic [3:0] lk);
        @(negedge clk);
        breq_ = rq;
        lock_ = lk;
        @(posedge clk);
        model_step(rq, lk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        breq_ = 4'b1111;
        lock_ = 4'b1111;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] breq;
        logic [3:0] bgrt;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [3:0] rq;
        logic [3:0] lk;

        // Single grant to 0, then full rotation 1,2,3,0 with 2-cycle tenures and idle gaps.
        tbl[0]  = '{4'b1110, 4'b1110, 2'd0, 1'b1};
        tbl[1]  = '{4'b1110, 4'b1110, 2'd0, 1'b1};
        tbl[2]  = '{4'b1111, 4'b1111, 2'd0, 1'b0};
        tbl[3]  = '{4'b0000, 4'b1101, 2'd1, 1'b1};
        tbl[4]  = '{4'b0000, 4'b1101, 2'd1, 1'b1};
        tbl[5]  = '{4'b0010, 4'b1111, 2'd1, 1'b0};
        tbl[6]  = '{4'b0000, 4'b1011, 2'd2, 1'b1};
        tbl[7]  = '{4'b0000, 4'b1011, 2'd2, 1'b1};
        tbl[8]  = '{4'b0100, 4'b1111, 2'd2, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0111, 2'd3, 1'b1};
        tbl[10] = '{4'b0000, 4'b0111, 2'd3, 1'b1};
        tbl[11] = '{4'b1000, 4'b1111, 2'd3, 1'b0};
        tbl[12] = '{4'b0000, 4'b1110, 2'd0, 1'b1};
        tbl[13] = '{4'b0000, 4'b1110, 2'd0, 1'b1};
        tbl[14] = '{4'b0001, 4'b1111, 2'd0, 1'b0};
        tbl[15] = '{4'b1111, 4'b1111, 2'd0, 1'b0};

        reset = 1'b1;
        breq_ = 4'b1111;
        lock_ = 4'b1111;
        model_reset();
        #1;
        chk("rst.bgrt", 32'(bgrt_), 32'hF);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.preempt", 32'(preempt), 32'd0);
        chk("rst.id", 32'(gnt_id), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].breq, 4'b1111);
            chk($sformatf("tbl%0d.bgrt", i), 32'(bgrt_), 32'(tbl[i].bgrt));
            chk($sformatf("tbl%0d.id", i), 32'(gnt_id), 32'(tbl[i].id));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d.preempt", i), 32'(preempt), 32'd0);
        end

        // Timeout: owner 2 keeps the bus 4 cycles while 0 waits, then is preempted.
        pulse_reset();
        step(4'b1011, 4'b1111);
        chk("to.grant", 32'(bgrt_), 32'hB);
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 4'b1111);
            chk($sformatf("to.hold%0d", i), 32'(bgrt_), 32'hB);
            chk($sformatf("to.nopre%0d", i), 32'(preempt), 32'd0);
        end
        step(4'b1010, 4'b1111);
        chk("to.revoke", 32'(bgrt_), 32'hF);
        chk("to.preempt", 32'(preempt), 32'd1);
        chk("to.busy", 32'(busy), 32'd0);
        step(4'b1010, 4'b1111);
        chk("to.next", 32'(bgrt_), 32'hE);
        chk("to.pulse_end", 32'(preempt), 32'd0);

        // Locked owner is never preempted.
        pulse_reset();
        step(4'b1011, 4'b1111);
        for (int i = 0; i < 100; i++) begin
            step(4'b1010, 4'b1011);
            chk($sformatf("lock.hold%0d", i), 32'({bgrt_, preempt}), 32'({4'b1011, 1'b0}));
        end
        step(4'b1110, 4'b1111);
        chk("lock.release", 32'(bgrt_), 32'hF);
        step(4'b1110, 4'b1111);
        chk("lock.next", 32'(bgrt_), 32'hE);

        // Release on the timeout edge counts as a release; round-robin continues at 3.
        pulse_reset();
        step(4'b1011, 4'b1111);
        for (int i = 0; i < 3; i++) step(4'b1010, 4'b1111);
        chk("coinc.held", 32'(bgrt_), 32'hB);
        step(4'b1110, 4'b1111);
        chk("coinc.bgrt", 32'(bgrt_), 32'hF);
        chk("coinc.preempt", 32'(preempt), 32'd0);
        step(4'b0010, 4'b1111);
        chk("coinc.next", 32'(bgrt_), 32'h7);
        chk("coinc.id", 32'(gnt_id), 32'd3);
        step(4'b1111, 4'b1111);

        // Asynchronous reset mid-grant drops the grant before the next edge.
        step(4'b1011, 4'b1111);
        chk("arst.pre", 32'(bgrt_), 32'hB);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.bgrt", 32'(bgrt_), 32'hF);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.id", 32'(gnt_id), 32'd0);
        reset = 1'b0;
        model_reset();
        step(4'b0000, 4'b1111);
        chk("arst.regrant", 32'(bgrt_), 32'hD);
        chk("arst.regrant_id", 32'(gnt_id), 32'd1);
        step(4'b0010, 4'b1111);
        chk("arst.release", 32'(bgrt_), 32'hF);

        // Random run against the model; the owner tends to keep requesting.
        for (int n = 0; n < 3000; n++) begin
            rq = 4'($urandom);
            lk = 4'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) rq[m_owner] = 1'b0;
            if (m_owner >= 0 && $urandom_range(0, 1) == 0) lk[m_owner] = 1'b1;
            step(rq, lk);
            check_model("rnd");
            if ($urandom_range(0, 249) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                reset = 1'b0;
                model_reset();
                check_model("rnd_rst");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
